sf_tester_pattern_engine: RTL and testbench

- Byte-pattern source and sink for the serial-flash tester.
- Sits between the tester FSM and the SPI flash command driver.
- During page-program, streams pattern bytes into the driver's TX path one page at a time.
- During read-back, compares the driver's RX bytes against the same pattern and accumulates error statistics for the final display.
- Patterns A-D are fixed start/increment pairs: A=00/01, B=08/07, C=10/0F, D=18/17.

---
 rtl/sf_tester_pattern_engine.sv | 171 +++++++++++++++++
 tb/tb_sf_tester_pattern_engine.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf_tester_pattern_engine.sv
// Pattern engine for the serial-flash tester.
// The generator streams one page of pattern bytes into the SPI driver TX path.
// The checker compares read-back bytes against the same pattern and keeps error statistics.
// Byte n of a pattern is start + n*incr (mod 256).
// The generator and the checker each step their own accumulator by incr.
//
// Handshake: a generated byte moves only on a cycle where o_gen_valid and
// i_gen_ready are both high. While valid is high and ready is low, o_gen_data
// holds its value. Once valid is raised, it stays high until that byte is taken.
`timescale 1ns/1ps

module sf_tester_pattern_engine #(
    parameter int PAGE_BYTES = 256,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk_40mhz,
    input  logic             i_rstn_40mhz,
    input  logic [1:0]       i_pattern_sel,
    input  logic             i_load,
    input  logic             i_gen_page_start,
    output logic             o_gen_valid,
    output logic [7:0]       o_gen_data,
    input  logic             i_gen_ready,
    output logic             o_gen_page_done,
    output logic             o_gen_busy,
    input  logic             i_chk_valid,
    input  logic [7:0]       i_chk_data,
    output logic [CNT_W-1:0] o_chk_byte_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_err_flag,
    output logic [CNT_W-1:0] o_first_err_idx,
    output logic [1:0]       o_dbg_gen_state
);

    localparam int PC_W = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;
    localparam logic [PC_W-1:0] LAST_BYTE = PC_W'(PAGE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } gen_state_e;

    gen_state_e       state_q, state_d;
    logic [7:0]       start_q, incr_q;
    logic [7:0]       sel_start, sel_incr;
    logic [7:0]       gen_acc_q, gen_acc_d;
    logic [PC_W-1:0]  page_cnt_q, page_cnt_d;
    logic [7:0]       chk_acc_q;
    logic [CNT_W-1:0] byte_cnt_q, err_cnt_q, first_idx_q;
    logic             err_flag_q;
    logic             chk_mismatch;

    // Decode the selected pattern into its start value and per-byte increment.
    always_comb begin
        sel_start = 8'h00;
        sel_incr  = 8'h01;
        case (i_pattern_sel)
            2'd0:    begin sel_start = 8'h00; sel_incr = 8'h01; end
            2'd1:    begin sel_start = 8'h08; sel_incr = 8'h07; end
            2'd2:    begin sel_start = 8'h10; sel_incr = 8'h0F; end
            default: begin sel_start = 8'h18; sel_incr = 8'h17; end
        endcase
    end

    // Latch the pattern on load; pattern select is ignored at all other times.
    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            start_q <= 8'h00;
            incr_q  <= 8'h01;
        end else if (i_load) begin
            start_q <= sel_start;
            incr_q  <= sel_incr;
        end
    end

    // Generator state, accumulator and page byte counter.
    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            state_q    <= ST_IDLE;
            gen_acc_q  <= 8'h00;
            page_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gen_acc_q  <= gen_acc_d;
            page_cnt_q <= page_cnt_d;
        end
    end

    // Generator next state. A load takes priority over everything and aborts any page in progress.
    // The accumulator is not reset between pages, so consecutive pages continue the sequence.
    always_comb begin
        state_d    = state_q;
        gen_acc_d  = gen_acc_q;
        page_cnt_d = page_cnt_q;
        if (i_load) begin
            state_d    = ST_IDLE;
            gen_acc_d  = sel_start;
            page_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_gen_page_start) begin
                        state_d    = ST_STREAM;
                        page_cnt_d = '0;
                    end
                end
                ST_STREAM: begin
                    if (i_gen_ready) begin
                        gen_acc_d  = gen_acc_q + incr_q;
                        page_cnt_d = page_cnt_q + PC_W'(1);
                        if (page_cnt_q == LAST_BYTE) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Generator outputs decode straight from the registered state.
    assign o_gen_valid     = (state_q == ST_STREAM);
    assign o_gen_data      = gen_acc_q;
    assign o_gen_page_done = (state_q == ST_DONE);
    assign o_gen_busy      = (state_q != ST_IDLE);
    assign o_dbg_gen_state = state_q;

    // Compare the incoming read-back byte against the checker's expected byte.
    assign chk_mismatch = (i_chk_data != chk_acc_q);

    // Checker statistics update one cycle after the strobe. A byte that arrives together with a load is dropped.
    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            chk_acc_q   <= 8'h00;
            byte_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_idx_q <= '0;
        end else if (i_load) begin
            chk_acc_q   <= sel_start;
            byte_cnt_q  <= '0;
            err_cnt_q   <= '0;
            err_flag_q  <= 1'b0;
            first_idx_q <= '0;
        end else if (i_chk_valid) begin
            chk_acc_q  <= chk_acc_q + incr_q;
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
            if (chk_mismatch) begin
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + CNT_W'(1);
                end
                if (!err_flag_q) begin
                    err_flag_q  <= 1'b1;
                    first_idx_q <= byte_cnt_q;
                end
            end
        end
    end

    assign o_chk_byte_count = byte_cnt_q;
    assign o_err_count      = err_cnt_q;
    assign o_err_flag       = err_flag_q;
    assign o_first_err_idx  = first_idx_q;

endmodule

// File: tb/tb_sf_tester_pattern_engine.sv
// Bench for sf_tester_pattern_engine.
// The pattern model computes each byte as start + n*incr, using the byte index since the last load.
`timescale 1ns/1ps

module tb_sf_tester_pattern_engine;

    localparam int PB = 256;
    localparam int CW = 32;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rstn;
    logic [1:0]    i_pattern_sel;
    logic          i_load, i_gen_page_start, i_gen_ready, i_chk_valid;
    logic [7:0]    i_chk_data;
    logic          o_gen_valid, o_gen_page_done, o_gen_busy, o_err_flag;
    logic [7:0]    o_gen_data;
    logic [CW-1:0] o_chk_byte_count, o_err_count, o_first_err_idx;
    logic [1:0]    o_dbg_gen_state;

    always #12.5 clk = ~clk;

    sf_tester_pattern_engine #(.PAGE_BYTES(PB), .CNT_W(CW)) dut (
        .i_clk_40mhz      (clk),
        .i_rstn_40mhz     (rstn),
        .i_pattern_sel    (i_pattern_sel),
        .i_load           (i_load),
        .i_gen_page_start (i_gen_page_start),
        .o_gen_valid      (o_gen_valid),
        .o_gen_data       (o_gen_data),
        .i_gen_ready      (i_gen_ready),
        .o_gen_page_done  (o_gen_page_done),
        .o_gen_busy       (o_gen_busy),
        .i_chk_valid      (i_chk_valid),
        .i_chk_data       (i_chk_data),
        .o_chk_byte_count (o_chk_byte_count),
        .o_err_count      (o_err_count),
        .o_err_flag       (o_err_flag),
        .o_first_err_idx  (o_first_err_idx),
        .o_dbg_gen_state  (o_dbg_gen_state)
    );

    // ---------------- reference model / scoreboard ----------------
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned m_start  = 0;
    int unsigned m_incr   = 1;
    int unsigned gen_n    = 0;
    int unsigned chk_n    = 0;
    int unsigned m_errs   = 0;
    bit          m_flag   = 1'b0;
    int unsigned m_first  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_page [PB];

    function automatic logic [7:0] pat_byte(input int unsigned n);
        return 8'((m_start + n * m_incr) % 256);
    endfunction

    function automatic void pat_of(input int sel, output int unsigned s, output int unsigned inc);
        case (sel)
            0:       begin s = 'h00; inc = 'h01; end
            1:       begin s = 'h08; inc = 'h07; end
            2:       begin s = 'h10; inc = 'h0F; end
            default: begin s = 'h18; inc = 'h17; end
        endcase
    endfunction

    function automatic void model_clear(input int unsigned s, input int unsigned inc);
        m_start = s;
        m_incr  = inc;
        gen_n   = 0;
        chk_n   = 0;
        m_errs  = 0;
        m_flag  = 1'b0;
        m_first = 0;
        exp_q.delete();
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int sel);
        int unsigned s, inc;
        step();
        i_pattern_sel = 2'(sel);
        i_load = 1'b1;
        step();
        i_load = 1'b0;
        i_pattern_sel = 2'($urandom_range(3));  // must be ignored outside a load
        pat_of(sel, s, inc);
        model_clear(s, inc);
    endtask

    task automatic check_stats(input string tag);
        check_eq({tag, "_bytes"}, o_chk_byte_count, chk_n);
        check_eq({tag, "_errs"},  o_err_count, m_errs);
        check_eq({tag, "_flag"},  {31'd0, o_err_flag}, {31'd0, m_flag});
        check_eq({tag, "_first"}, o_first_err_idx, m_first);
    endtask

    // Stream one page; stall_pct is the chance of ready being low in any cycle.
    task automatic gen_page(input int stall_pct);
        int accepted = 0;
        int cycles = 0;
        for (int i = 0; i < PB; i++) exp_q.push_back(pat_byte(gen_n + i));
        step();
        i_gen_page_start = 1'b1;
        i_gen_ready = ($urandom_range(99) >= stall_pct);
        @(negedge clk);
        check_eq("gen_valid_before_start", {31'd0, o_gen_valid}, 32'd0);
        step();
        i_gen_page_start = 1'b0;
        while (accepted < PB && cycles < 4000) begin
            @(negedge clk);
            check_eq("gen_valid", {31'd0, o_gen_valid}, 32'd1);
            check_eq("gen_busy", {31'd0, o_gen_busy}, 32'd1);
            check_eq("gen_done_early", {31'd0, o_gen_page_done}, 32'd0);
            check_eq("gen_data", {24'd0, o_gen_data}, {24'd0, exp_q[0]});
            if (i_gen_ready) begin
                last_page[accepted] = o_gen_data;
                void'(exp_q.pop_front());
                accepted++;
                gen_n++;
            end
            step();
            i_gen_page_start = ($urandom_range(3) == 0);  // ignored while busy
            i_gen_ready = ($urandom_range(99) >= stall_pct);
            cycles++;
        end
        i_gen_page_start = 1'b0;
        check_eq("gen_accepted", accepted, PB);
        @(negedge clk);
        check_eq("gen_valid_after", {31'd0, o_gen_valid}, 32'd0);
        check_eq("gen_done_pulse", {31'd0, o_gen_page_done}, 32'd1);
        check_eq("gen_busy_in_done", {31'd0, o_gen_busy}, 32'd1);
        @(negedge clk);
        check_eq("gen_done_cleared", {31'd0, o_gen_page_done}, 32'd0);
        check_eq("gen_busy_cleared", {31'd0, o_gen_busy}, 32'd0);
    endtask

    // Feed n read-back bytes. Indices bad_a and bad_b are always corrupted; other bytes are corrupted at random with err_pct.
    task automatic chk_feed(input int n, input int bad_a, input int bad_b, input int err_pct, input int gap_pct);
        int sent = 0;
        while (sent < n) begin
            step();
            if ($urandom_range(99) < gap_pct) begin
                i_chk_valid = 1'b0;
                i_chk_data  = 8'($urandom);
            end else begin
                bit bad;
                bad = (int'(chk_n) == bad_a) || (int'(chk_n) == bad_b) || ($urandom_range(99) < err_pct);
                i_chk_valid = 1'b1;
                i_chk_data  = pat_byte(chk_n) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
                if (bad) begin
                    if (!m_flag) m_first = chk_n;
                    m_flag = 1'b1;
                    m_errs++;
                end
                chk_n++;
                sent++;
            end
        end
        step();
        i_chk_valid = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int acc;
        rstn = 1'b0;
        i_pattern_sel = 2'd0;
        i_load = 1'b0;
        i_gen_page_start = 1'b0;
        i_gen_ready = 1'b0;
        i_chk_valid = 1'b0;
        i_chk_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {31'd0, o_gen_valid}, 32'd0);
        check_eq("rst_data", {24'd0, o_gen_data}, 32'd0);
        check_eq("rst_done", {31'd0, o_gen_page_done}, 32'd0);
        check_eq("rst_busy", {31'd0, o_gen_busy}, 32'd0);
        check_eq("rst_state", {30'd0, o_dbg_gen_state}, 32'd0);
        check_stats("rst");
        step();
        rstn = 1'b1;

        // Pattern B, ready always high
        do_load(1);
        gen_page(0);
        check_eq("B_b0", {24'd0, last_page[0]}, 32'h08);
        check_eq("B_b1", {24'd0, last_page[1]}, 32'h0F);
        check_eq("B_b2", {24'd0, last_page[2]}, 32'h16);
        check_eq("B_b35", {24'd0, last_page[35]}, 32'hFD);
        check_eq("B_b36", {24'd0, last_page[36]}, 32'h04);

        // Pattern A with stalls, two back-to-back pages
        do_load(0);
        gen_page(40);
        check_eq("A_p1_b0", {24'd0, last_page[0]}, 32'h00);
        check_eq("A_p1_b255", {24'd0, last_page[255]}, 32'hFF);
        gen_page(40);
        check_eq("A_p2_b0", {24'd0, last_page[0]}, 32'h00);

        // Pattern D, 512 clean read-back bytes
        do_load(3);
        chk_feed(512, -1, -1, 0, 20);
        check_stats("D_clean");
        check_eq("D_bytes_512", o_chk_byte_count, 32'd512);
        check_eq("D_flag_0", {31'd0, o_err_flag}, 32'd0);

        // Pattern C, corrupt bytes 5 and 100
        do_load(2);
        chk_feed(256, 5, 100, 0, 10);
        check_stats("C_err");
        check_eq("C_errs_2", o_err_count, 32'd2);
        check_eq("C_first_5", o_first_err_idx, 32'd5);
        check_eq("C_bytes_256", o_chk_byte_count, 32'd256);

        // Random pattern, generator and checker running at the same time
        for (int r = 0; r < 2; r++) begin
            do_load(int'($urandom_range(3)));
            fork
                gen_page(30);
                chk_feed(300, -1, -1, 8, 30);
            join
            check_stats("conc");
        end

        // A load arriving mid-page aborts the page and drops the checker byte that arrives with it
        do_load(0);
        chk_feed(10, -1, -1, 0, 0);
        step();
        i_gen_page_start = 1'b1;
        i_gen_ready = 1'b1;
        step();
        i_gen_page_start = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 1000) begin
            @(negedge clk);
            if (o_gen_valid) acc++;
            step();
            cyc++;
        end
        check_eq("abort_reached_100", acc, 100);
        i_load = 1'b1;
        i_pattern_sel = 2'd3;
        i_chk_valid = 1'b1;
        i_chk_data = 8'h5A;
        i_gen_page_start = 1'b1;
        step();
        i_load = 1'b0;
        i_chk_valid = 1'b0;
        i_gen_page_start = 1'b0;
        model_clear('h18, 'h17);
        @(negedge clk);
        check_eq("abort_valid", {31'd0, o_gen_valid}, 32'd0);
        check_eq("abort_busy", {31'd0, o_gen_busy}, 32'd0);
        check_eq("abort_done", {31'd0, o_gen_page_done}, 32'd0);
        check_eq("abort_acc", {24'd0, o_gen_data}, {24'd0, pat_byte(0)});
        check_stats("abort");
        @(negedge clk);
        check_eq("abort_no_done", {31'd0, o_gen_page_done}, 32'd0);
        check_eq("abort_state", {30'd0, o_dbg_gen_state}, 32'd0);
        gen_page(0);
        check_eq("abort_restart_b0", {24'd0, last_page[0]}, 32'h18);
        chk_feed(20, 3, -1, 0, 0);
        check_stats("abort_chk");

        // Asynchronous reset partway through a page
        step();
        i_gen_page_start = 1'b1;
        i_gen_ready = 1'b1;
        step();
        i_gen_page_start = 1'b0;
        acc = 0;
        cyc = 0;
        while (acc < 50 && cyc < 1000) begin
            @(negedge clk);
            if (o_gen_valid) acc++;
            step();
            cyc++;
        end
        #5;
        rstn = 1'b0;
        #1;
        model_clear(0, 1);
        check_eq("arst_valid", {31'd0, o_gen_valid}, 32'd0);
        check_eq("arst_data", {24'd0, o_gen_data}, 32'd0);
        check_eq("arst_busy", {31'd0, o_gen_busy}, 32'd0);
        check_stats("arst");
        i_gen_ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
        @(negedge clk);
        check_eq("arst_idle_after", {31'd0, o_gen_busy}, 32'd0);
        gen_page(10);
        check_eq("arst_restart_b0", {24'd0, last_page[0]}, 32'h00);
        chk_feed(30, -1, -1, 20, 10);
        check_stats("arst_chk");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so a stuck handshake cannot hang the run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
